multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle RISC-V RV32I control unit (Moore FSM plus combinational ALU decoding). It is the sequential successor to the single-cycle controller.
- It sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- It is parametrised in ALU-control width and branch coverage, and has an optional memory wait-state handshake.
- It sits between the instruction register and the multicycle datapath muxes and enables.

Parameters:
- ALU_CTRL_W, 4, width of alu_ctrl_o. Must be 3 or 4; 3 supports add/sub/and/or/slt only.
- BRANCH_FULL, 1, 1 = all six B-type conditions; 0 = beq/bne only, other funct3 treated as illegal.
- MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready_i; 0 = mem_ready_i ignored (treated as 1).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- op_i  in  7  opcode from instruction register
- funct3_i  in  3  instr[14:12]
- funct7b5_i  in  1  instr[30]
- zero_flag_i  in  1  ALU result == 0
- lt_flag_i  in  1  signed rs1 < rs2
- ltu_flag_i  in  1  unsigned rs1 < rs2
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  PC register enable
- adr_src_o  out  1  0 = PC, 1 = ALUOut to memory address
- mem_req_o  out  1  memory access request
- mem_write_o  out  1  store strobe
- ir_write_o  out  1  IR/oldPC enable
- reg_write_o  out  1  register file write enable
- result_src_o  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a_o  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero
- alu_src_b_o  out  2  00 = rs2, 01 = imm, 10 = constant 4
- imm_src_o  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- alu_ctrl_o  out  ALU_CTRL_W  ALU operation
- illegal_o  out  1  one-cycle pulse on unsupported instruction
- state_o  out  4  current state, for debug

Behaviour:
- Reset (async, during any state): state = FETCH. Only registered output is illegal_o, which resets to 0. All other outputs are decoded from state, so they take FETCH values immediately.
- States and next-state rules:
  - FETCH -> DECODE
  - DECODE -> MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU), BRANCH, JAL, LUI; any other opcode -> FETCH with illegal_o = 1 next cycle
  - MEMADR -> MEMREAD (lw) or MEMWRITE (sw)
  - MEMREAD -> MEMWB -> FETCH
  - MEMWRITE -> FETCH
  - EXECUTER, EXECUTEI, JAL, LUI -> ALUWB -> FETCH
  - BRANCH -> FETCH
- Wait states: FETCH, MEMREAD and MEMWRITE hold while mem_req_o = 1 and mem_ready_i = 0. In FETCH, ir_write_o and pc_write_o assert only in the cycle mem_ready_i = 1. In MEMWRITE, mem_write_o stays high through the wait.
- State outputs (unlisted outputs are 0):
  - FETCH: adr 0, req 1, a 00, b 10, add, result 10.
  - DECODE: a 01, b 01, add. Branch/jump target is computed here.
  - MEMADR: a 10, b 01, add.
  - MEMREAD: adr 1, req 1, result 00.
  - MEMWB: result 01, reg_write 1.
  - MEMWRITE: adr 1, req 1, mem_write 1, result 00.
  - EXECUTER: a 10, b 00, ALU op from funct decode.
  - EXECUTEI: a 10, b 01, ALU op from funct decode.
  - ALUWB: result 00, reg_write 1.
  - BRANCH: a 10, b 00, sub, result 00, pc_write = taken.
  - JAL: a 01, b 10, add, result 00, pc_write 1.
  - LUI: a 11, b 01, add.
- imm_src_o: decoded from op_i in every state.
- Branch taken, by funct3:
  - 000: zero
  - 001: !zero
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
  - 010/011, or non-beq/bne when BRANCH_FULL = 0: illegal at DECODE.
- ALU ctrl encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001. When ALU_CTRL_W = 3, use the low 3 bits; xor/sll/srl/sra/sltu are then illegal at DECODE.
- Funct decode: sub only for R-type with funct7b5 = 1; srai/sra for funct3 101 with funct7b5 = 1.
- Latency with mem_ready_i = 1 (cycles): lw 5, sw 4, R/I/jal/lui 4, branch 3. Each wait cycle adds 1.

Decomposition:
- Shared package ctrl_pkg: state_t enum (4-bit), opcode constants, ALU-op constants, result/src mux encodings, imm_src encodings.
- Sub-module mc_alu_decoder (combinational, parameter ALU_CTRL_W):
  - inputs: op, funct3, funct7b5, alu_op class (add/sub/funct)
  - outputs: alu_ctrl, unsupported flag

Test Plan:
- rst_i pulsed mid-MEMREAD -> state_o = FETCH same cycle, mem_req_o = 1, adr_src_o = 0, illegal_o = 0; lw then completes in 5 cycles.
- lw with mem_ready_i low 2 cycles in FETCH and 1 in MEMREAD -> 8 total cycles; ir_write_o high exactly once; reg_write_o high exactly once in MEMWB.
- bne with zero_flag_i = 0 -> pc_write_o = 1 in BRANCH; with zero_flag_i = 1 -> 0; 3 cycles each; bltu uses ltu_flag_i.
- R-type funct3 = 101, funct7b5 = 1 -> alu_ctrl_o = 1000 in EXECUTER; funct3 = 000, funct7b5 = 1 -> 0001.
- op_i = 0001111 -> DECODE then FETCH, illegal_o = 1 for exactly one cycle, no reg_write_o/mem_write_o.
- BRANCH_FULL = 0 with blt, or ALU_CTRL_W = 3 with xor -> illegal_o = 1 pulse; sw asserts mem_write_o only in MEMWRITE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM state
// encoding, opcode constants, ALU operation codes, datapath mux encodings
// and the immediate-format decode used by the controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    // ALU operation class requested by the FSM; FUNCT defers to funct3/funct7.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format follows the opcode only; unknown opcodes default to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_B:    return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the instruction register / flags and the
// multicycle datapath. master = controller side, slave = datapath side.
// Handshake: the controller raises mem_req_o and holds its state until the
// memory answers with mem_ready_i = 1 in the same cycle; that cycle completes
// the access.
interface multicycle_controller_if #(
    parameter int ALU_CTRL_W = 4
) ();
    logic [6:0]            op_i;
    logic [2:0]            funct3_i;
    logic                  funct7b5_i;
    logic                  zero_flag_i;
    logic                  lt_flag_i;
    logic                  ltu_flag_i;
    logic                  mem_ready_i;
    logic                  pc_write_o;
    logic                  adr_src_o;
    logic                  mem_req_o;
    logic                  mem_write_o;
    logic                  ir_write_o;
    logic                  reg_write_o;
    logic [1:0]            result_src_o;
    logic [1:0]            alu_src_a_o;
    logic [1:0]            alu_src_b_o;
    logic [2:0]            imm_src_o;
    logic [ALU_CTRL_W-1:0] alu_ctrl_o;
    logic                  illegal_o;
    logic [3:0]            state_o;

    modport master (
        input  op_i, funct3_i, funct7b5_i, zero_flag_i, lt_flag_i, ltu_flag_i, mem_ready_i,
        output pc_write_o, adr_src_o, mem_req_o, mem_write_o, ir_write_o, reg_write_o,
               result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o, alu_ctrl_o, illegal_o, state_o
    );

    modport slave (
        output op_i, funct3_i, funct7b5_i, zero_flag_i, lt_flag_i, ltu_flag_i, mem_ready_i,
        input  pc_write_o, adr_src_o, mem_req_o, mem_write_o, ir_write_o, reg_write_o,
               result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o, alu_ctrl_o, illegal_o, state_o
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder.
// Inputs : op_i, funct3_i, funct7b5_i, alu_op_i (add / sub / funct class).
// Outputs: alu_ctrl_o (ALU_CTRL_W bits), unsupported_o (the funct fields
//          name an operation this configuration cannot execute).
module mc_alu_decoder
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [6:0]            op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    input  alu_op_t               alu_op_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic                  unsupported_o
);
    localparam bit NARROW = (ALU_CTRL_W < 4);

    logic [3:0] funct_op;
    logic [3:0] sel_op;
    logic       bad_funct7;
    logic       narrow_bad;

    always_comb begin
        funct_op   = ALU_ADD;
        bad_funct7 = 1'b0;
        case (funct3_i)
            // For I-type, bit 30 is immediate data, so only R-type selects sub.
            3'b000:  funct_op = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_op = ALU_SLL;
            3'b010:  funct_op = ALU_SLT;
            3'b011:  funct_op = ALU_SLTU;
            3'b100:  funct_op = ALU_XOR;
            3'b101:  funct_op = funct7b5_i ? ALU_SRA : ALU_SRL;
            3'b110:  funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
        // R-type only defines bit 30 for sub and sra.
        if (op_i == OP_R && funct7b5_i && funct3_i != 3'b000 && funct3_i != 3'b101) begin
            bad_funct7 = 1'b1;
        end
    end

    always_comb begin
        case (alu_op_i)
            ALUOP_ADD: sel_op = ALU_ADD;
            ALUOP_SUB: sel_op = ALU_SUB;
            default:   sel_op = funct_op;
        endcase
    end

    // A 3-bit ALU only implements add/sub/and/or/slt.
    assign narrow_bad    = NARROW && !(funct_op == ALU_ADD || funct_op == ALU_SUB ||
                                       funct_op == ALU_AND || funct_op == ALU_OR ||
                                       funct_op == ALU_SLT);
    assign unsupported_o = bad_funct7 | narrow_bad;
    assign alu_ctrl_o    = sel_op[ALU_CTRL_W-1:0];

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over one shared ALU and one memory port.
// Ports: clk_i, rst_i (async, active-high) and the controller bundle
// (multicycle_controller_if.master). All outputs except illegal_o are
// decoded from the current state; illegal_o is a registered one-cycle pulse
// raised in the FETCH cycle following a rejected DECODE.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter bit BRANCH_FULL = 1'b1,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic                   clk_i,
    input logic                   rst_i,
    multicycle_controller_if.master bus
);
    state_t  state_q, state_d;
    logic    illegal_q, illegal_d;
    logic    mem_ready;
    logic    taken;
    logic    branch_ok;
    logic    alu_unsup;
    alu_op_t alu_op;

    assign mem_ready = MEM_WAIT_EN ? bus.mem_ready_i : 1'b1;

    mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .op_i         (bus.op_i),
        .funct3_i     (bus.funct3_i),
        .funct7b5_i   (bus.funct7b5_i),
        .alu_op_i     (alu_op),
        .alu_ctrl_o   (bus.alu_ctrl_o),
        .unsupported_o(alu_unsup)
    );

    always_comb begin
        case (bus.funct3_i)
            3'b000:  taken = bus.zero_flag_i;
            3'b001:  taken = !bus.zero_flag_i;
            3'b100:  taken = bus.lt_flag_i;
            3'b101:  taken = !bus.lt_flag_i;
            3'b110:  taken = bus.ltu_flag_i;
            3'b111:  taken = !bus.ltu_flag_i;
            default: taken = 1'b0;
        endcase
        if (BRANCH_FULL) begin
            branch_ok = (bus.funct3_i != 3'b010) && (bus.funct3_i != 3'b011);
        end else begin
            branch_ok = (bus.funct3_i == 3'b000) || (bus.funct3_i == 3'b001);
        end
    end

    // Next-state logic; a rejected DECODE returns to FETCH and arms illegal_q.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:   begin state_d = alu_unsup ? S_FETCH : S_EXECUTER; illegal_d = alu_unsup; end
                    OP_I:   begin state_d = alu_unsup ? S_FETCH : S_EXECUTEI; illegal_d = alu_unsup; end
                    OP_B:   begin state_d = branch_ok ? S_BRANCH : S_FETCH;   illegal_d = !branch_ok; end
                    OP_JAL: state_d = S_JAL;
                    OP_LUI: state_d = S_LUI;
                    default: begin state_d = S_FETCH; illegal_d = 1'b1; end
                endcase
            end
            S_MEMADR:   state_d = (bus.op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore output decode.
    always_comb begin
        bus.pc_write_o   = 1'b0;
        bus.adr_src_o    = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_write_o  = 1'b0;
        bus.ir_write_o   = 1'b0;
        bus.reg_write_o  = 1'b0;
        bus.result_src_o = RES_ALUOUT;
        bus.alu_src_a_o  = SRCA_PC;
        bus.alu_src_b_o  = SRCB_RS2;
        alu_op           = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                bus.mem_req_o    = 1'b1;
                bus.alu_src_b_o  = SRCB_FOUR;
                bus.result_src_o = RES_ALU;
                // IR and PC only capture when the fetch actually completes.
                bus.ir_write_o   = mem_ready;
                bus.pc_write_o   = mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_a_o = SRCA_OLDPC;
                bus.alu_src_b_o = SRCB_IMM;
            end
            S_MEMADR: begin
                bus.alu_src_a_o = SRCA_RS1;
                bus.alu_src_b_o = SRCB_IMM;
            end
            S_MEMREAD: begin
                bus.adr_src_o = 1'b1;
                bus.mem_req_o = 1'b1;
            end
            S_MEMWB: begin
                bus.result_src_o = RES_RDATA;
                bus.reg_write_o  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.adr_src_o   = 1'b1;
                bus.mem_req_o   = 1'b1;
                bus.mem_write_o = 1'b1;
            end
            S_EXECUTER: begin
                bus.alu_src_a_o = SRCA_RS1;
                alu_op          = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                bus.alu_src_a_o = SRCA_RS1;
                bus.alu_src_b_o = SRCB_IMM;
                alu_op          = ALUOP_FUNCT;
            end
            S_ALUWB:  bus.reg_write_o = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a_o = SRCA_RS1;
                alu_op          = ALUOP_SUB;
                bus.pc_write_o  = taken;
            end
            S_JAL: begin
                bus.alu_src_a_o = SRCA_OLDPC;
                bus.alu_src_b_o = SRCB_FOUR;
                bus.pc_write_o  = 1'b1;
            end
            S_LUI: begin
                bus.alu_src_a_o = SRCA_ZERO;
                bus.alu_src_b_o = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign bus.imm_src_o = imm_src_of(bus.op_i);
    assign bus.illegal_o = illegal_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
    import ctrl_pkg::*;

    localparam int RW = 38;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [6:0] op;
    logic [2:0] f3;
    logic       b5, zf, ltf, ltuf, rdy;

    multicycle_controller_if #(.ALU_CTRL_W(4)) bus_main ();
    multicycle_controller_if #(.ALU_CTRL_W(3)) bus_lite ();

    assign bus_main.op_i = op;   assign bus_lite.op_i = op;
    assign bus_main.funct3_i = f3; assign bus_lite.funct3_i = f3;
    assign bus_main.funct7b5_i = b5; assign bus_lite.funct7b5_i = b5;
    assign bus_main.zero_flag_i = zf; assign bus_lite.zero_flag_i = zf;
    assign bus_main.lt_flag_i = ltf; assign bus_lite.lt_flag_i = ltf;
    assign bus_main.ltu_flag_i = ltuf; assign bus_lite.ltu_flag_i = ltuf;
    assign bus_main.mem_ready_i = rdy; assign bus_lite.mem_ready_i = rdy;

    multicycle_controller #(.ALU_CTRL_W(4), .BRANCH_FULL(1'b1), .MEM_WAIT_EN(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus_main)
    );
    multicycle_controller #(.ALU_CTRL_W(3), .BRANCH_FULL(1'b0), .MEM_WAIT_EN(1'b0)) dut_lite (
        .clk_i(clk), .rst_i(rst), .bus(bus_lite)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [6:0] op; logic [2:0] f3; logic b5, zf, lt, ltu;
        int wf, wm;
        int cyc, pcw, regw, memw; logic taken; logic [3:0] alu; logic [2:0] imm; int ill;
    } vec_t;

    function automatic logic [RW-1:0] pack(input int cyc, input int irw, input int pcw,
                                           input int regw, input int memw, input int mout,
                                           input logic taken, input logic [3:0] alu,
                                           input logic [2:0] imm, input int ill);
        return {8'(cyc), 4'(irw), 4'(pcw), 4'(regw), 4'(memw), 4'(mout), taken, alu, imm, 2'(ill)};
    endfunction

    // {adr_src, mem_req, result_src, alu_src_a, alu_src_b} for each state.
    function automatic logic [7:0] exp_sig(input logic [3:0] st);
        case (st)
            4'd0:    return 8'b0_1_10_00_10;
            4'd1:    return 8'b0_0_00_01_01;
            4'd2:    return 8'b0_0_00_10_01;
            4'd3:    return 8'b1_1_00_00_00;
            4'd4:    return 8'b0_0_01_00_00;
            4'd5:    return 8'b1_1_00_00_00;
            4'd6:    return 8'b0_0_00_10_00;
            4'd7:    return 8'b0_0_00_10_01;
            4'd8:    return 8'b0_0_00_00_00;
            4'd9:    return 8'b0_0_00_10_00;
            4'd10:   return 8'b0_0_00_01_10;
            4'd11:   return 8'b0_0_00_11_01;
            default: return 8'hff;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Entered at a negedge while the DUT is in the instruction's first FETCH;
    // returns at the negedge of the next instruction's first FETCH.
    task automatic run_instr(input string tag, input vec_t v, output logic [RW-1:0] got);
        int cyc = 0, wf = v.wf, wm = v.wm;
        int irw = 0, pcw = 0, regw = 0, memw = 0, mout = 0, ill = 0;
        logic taken = 1'b0;
        logic [3:0] alu = 4'd0, st;
        logic [2:0] imm = 3'd0;
        bit seen = 0, done = 0;
        op = v.op; f3 = v.f3; b5 = v.b5; zf = v.zf; ltf = v.lt; ltuf = v.ltu;
        while (!done) begin
            st = bus_main.state_o;
            if (st == 4'd0 && wf > 0) begin rdy = 1'b0; wf--; end
            else if ((st == 4'd3 || st == 4'd5) && wm > 0) begin rdy = 1'b0; wm--; end
            else rdy = 1'b1;
            #1;
            check($sformatf("%s.sig.c%0d", tag, cyc),
                  {bus_main.adr_src_o, bus_main.mem_req_o, bus_main.result_src_o,
                   bus_main.alu_src_a_o, bus_main.alu_src_b_o}, exp_sig(st));
            if (st != 4'd6 && st != 4'd7)
                check($sformatf("%s.alu_fixed.c%0d", tag, cyc), bus_main.alu_ctrl_o,
                      (st == 4'd9) ? 32'd1 : 32'd0);
            irw  += bus_main.ir_write_o;
            pcw  += bus_main.pc_write_o;
            regw += bus_main.reg_write_o;
            if (bus_main.mem_write_o) begin
                if (st == 4'd5) memw++; else mout++;
            end
            if (cyc > 0) ill += bus_main.illegal_o;
            if (st == 4'd9) taken = bus_main.pc_write_o;
            if (st == 4'd6 || st == 4'd7) alu = bus_main.alu_ctrl_o;
            if (st == 4'd1) imm = bus_main.imm_src_o;
            if (st != 4'd0) seen = 1;
            cyc++;
            @(negedge clk);
            if (seen && bus_main.state_o == 4'd0) begin
                ill += bus_main.illegal_o;
                done = 1;
            end else if (cyc >= 40) begin
                total++; bad++;
                $display("FAIL %s.timeout: got %0d cycles required completion", tag, cyc);
                done = 1;
            end
        end
        got = pack(cyc, irw, pcw, regw, memw, mout, taken, alu, imm, ill);
    endtask

    task automatic compare_res(input string tag, input logic [RW-1:0] g, input logic [RW-1:0] e);
        check({tag, ".cycles"},   g[37:30], e[37:30]);
        check({tag, ".ir_write"}, g[29:26], e[29:26]);
        check({tag, ".pc_write"}, g[25:22], e[25:22]);
        check({tag, ".reg_write"}, g[21:18], e[21:18]);
        check({tag, ".mem_write"}, g[17:14], e[17:14]);
        check({tag, ".mem_write_outside"}, g[13:10], e[13:10]);
        check({tag, ".taken"},    g[9], e[9]);
        check({tag, ".alu_ctrl"}, g[8:5], e[8:5]);
        check({tag, ".imm_src"},  g[4:2], e[4:2]);
        check({tag, ".illegal"},  g[1:0], e[1:0]);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [RW-1:0] got, exp;
        exp_q.push_back(pack(v.cyc, 1, v.pcw, v.regw, v.memw, 0, v.taken, v.alu, v.imm, v.ill));
        run_instr(tag, v, got);
        exp = exp_q.pop_front();
        compare_res(tag, got, exp);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f, input logic b,
                                input logic z, input logic l, input logic lu,
                                input int wf, input int wm, input int cyc, input int pcw,
                                input int regw, input int memw, input logic tk,
                                input logic [3:0] alu, input logic [2:0] imm, input int ill);
        vec_t v;
        v.op = o; v.f3 = f; v.b5 = b; v.zf = z; v.lt = l; v.ltu = lu; v.wf = wf; v.wm = wm;
        v.cyc = cyc; v.pcw = pcw; v.regw = regw; v.memw = memw; v.taken = tk;
        v.alu = alu; v.imm = imm; v.ill = ill;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        op = OP_R; f3 = 3'd0; b5 = 1'b0; zf = 1'b0; ltf = 1'b0; ltuf = 1'b0; rdy = 1'b1;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check("reset.state", bus_main.state_o, 32'd0);
        check("reset.mem_req", bus_main.mem_req_o, 32'd1);
        check("reset.adr_src", bus_main.adr_src_o, 32'd0);
        check("reset.illegal", bus_main.illegal_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //            op      f3     b5 z  lt ltu wf wm cyc pcw rw mw tk alu    imm ill
        vecs.push_back(mk(OP_LW, 3'd2, 0, 0, 0, 0, 2, 1, 8, 1, 1, 0, 0, 4'd0, 3'd0, 0));
        vecs.push_back(mk(OP_LW, 3'd2, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 4'd0, 3'd0, 0));
        vecs.push_back(mk(OP_SW, 3'd2, 0, 0, 0, 0, 0, 2, 6, 1, 0, 3, 0, 4'd0, 3'd1, 0));
        vecs.push_back(mk(OP_SW, 3'd2, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 4'd0, 3'd1, 0));
        vecs.push_back(mk(OP_R,  3'd5, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd8, 3'd0, 0));
        vecs.push_back(mk(OP_R,  3'd0, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd1, 3'd0, 0));
        vecs.push_back(mk(OP_R,  3'd0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd0, 3'd0, 0));
        vecs.push_back(mk(OP_R,  3'd3, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd9, 3'd0, 0));
        vecs.push_back(mk(OP_R,  3'd1, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd6, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd0, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd0, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd5, 1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd8, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd5, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd7, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd4, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd4, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd7, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd2, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd6, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd3, 3'd0, 0));
        vecs.push_back(mk(OP_I,  3'd2, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd5, 3'd0, 0));
        vecs.push_back(mk(OP_B,  3'd1, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 1, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd1, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd0, 0, 1, 0, 0, 0, 0, 3, 2, 0, 0, 1, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd6, 0, 0, 0, 1, 0, 0, 3, 2, 0, 0, 1, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd6, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd5, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd4, 0, 0, 1, 0, 0, 0, 3, 2, 0, 0, 1, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_B,  3'd0, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 4'd0, 3'd2, 0));
        vecs.push_back(mk(OP_JAL, 3'd0, 0, 0, 0, 0, 0, 0, 4, 2, 1, 0, 0, 4'd0, 3'd3, 0));
        vecs.push_back(mk(OP_LUI, 3'd0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd0, 3'd4, 0));
        vecs.push_back(mk(7'b0001111, 3'd0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 4'd0, 3'd0, 1));
        vecs.push_back(mk(OP_R,  3'd0, 0, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0, 4'd0, 3'd0, 0));
        vecs.push_back(mk(OP_B,  3'd2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 4'd0, 3'd2, 1));
        vecs.push_back(mk(OP_SW, 3'd2, 0, 0, 0, 0, 1, 0, 5, 1, 0, 1, 0, 4'd0, 3'd1, 0));

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset asserted asynchronously in the middle of MEMREAD.
        op = OP_LW; f3 = 3'd2; b5 = 1'b0; rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rstmid.pre_state", bus_main.state_o, 32'd3);
        rst = 1'b1;
        #1;
        check("rstmid.state", bus_main.state_o, 32'd0);
        check("rstmid.mem_req", bus_main.mem_req_o, 32'd1);
        check("rstmid.adr_src", bus_main.adr_src_o, 32'd0);
        check("rstmid.illegal", bus_main.illegal_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("rstmid.lw", mk(OP_LW, 3'd2, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 0, 4'd0, 3'd0, 0));

        // Reduced configuration: blt is not a supported branch.
        reset_all();
        op = OP_B; f3 = 3'd4; b5 = 1'b0; ltf = 1'b1; rdy = 1'b1;
        @(negedge clk);
        check("lite.blt.decode", bus_lite.state_o, 32'd1);
        @(negedge clk);
        check("lite.blt.state", bus_lite.state_o, 32'd0);
        check("lite.blt.illegal", bus_lite.illegal_o, 32'd1);
        check("main.blt.state", bus_main.state_o, 32'd9);
        check("main.blt.illegal", bus_main.illegal_o, 32'd0);
        @(negedge clk);
        check("lite.blt.illegal_end", bus_lite.illegal_o, 32'd0);

        // Reduced configuration: xor needs a 4-bit ALU; mem_ready_i is ignored.
        reset_all();
        op = OP_R; f3 = 3'd4; b5 = 1'b0; rdy = 1'b0;
        @(negedge clk);
        check("lite.xor.decode", bus_lite.state_o, 32'd1);
        check("main.xor.fetch_wait", bus_main.state_o, 32'd0);
        @(negedge clk);
        check("lite.xor.state", bus_lite.state_o, 32'd0);
        check("lite.xor.illegal", bus_lite.illegal_o, 32'd1);
        @(negedge clk);
        check("lite.xor.illegal_end", bus_lite.illegal_o, 32'd0);

        // Reduced configuration: sub is still encoded in 3 bits.
        reset_all();
        op = OP_R; f3 = 3'd0; b5 = 1'b1; rdy = 1'b1;
        @(negedge clk); @(negedge clk);
        #1;
        check("lite.sub.state", bus_lite.state_o, 32'd6);
        check("lite.sub.alu", bus_lite.alu_ctrl_o, 32'd1);
        check("main.sub.alu", bus_main.alu_ctrl_o, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
